async_fifo: RTL and testbench
=============================

# async_fifo

Dual-pointer FIFO buffer of DATA_WIDTH-bit words between a producer (write side) and a consumer (read side), both clocked by one clock. It uses Gray-coded pointers that pass through synchronizer flops, the same architecture as a clock-domain-crossing FIFO. This keeps the block drop-in convertible to two clock domains, at the cost of conservative flag latency. It sits between a streaming source and sink anywhere in the datapath.

## Interface
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 4, log2 of depth; depth = 2^ADDR_WIDTH = 16 words.
- SYNC_STAGES, 2, synchronizer flops per pointer crossing (minimum 2).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- winc  in  1  write request.
- wdata  in  DATA_WIDTH  write data, sampled with an accepted write.
- wfull  out  1  FIFO full; writes ignored while high.
- rinc  in  1  read request.
- rempty  out  1  FIFO empty; reads ignored while high.
- rdata  out  DATA_WIDTH  head-of-FIFO word (first-word fall-through).

## Operation
- Write accepted when winc && !wfull: mem[wptr[ADDR_WIDTH-1:0]] <= wdata, wptr increments.
- Read accepted when rinc && !rempty: rptr increments.
- wptr and rptr are binary, ADDR_WIDTH+1 bits, and wrap modulo 2^(ADDR_WIDTH+1). The MSB distinguishes full from empty.
- Registered Gray copies: wgray = wbin ^ (wbin >> 1); rgray likewise.
- wgray passes through SYNC_STAGES flops to the read-side logic (rq_wgray). rgray passes through SYNC_STAGES flops to the write-side logic (wq_rgray).
- wfull register: wfull <= (wgray_next == {~wq_rgray[top two bits], wq_rgray[remaining bits]}).
- rempty register: rempty <= (rgray_next == rq_wgray).
- wgray_next and rgray_next are the Gray form of the post-increment pointer, i.e. after this cycle's accepted operation.
- rdata = mem[rptr[ADDR_WIDTH-1:0]], combinational from memory. It is valid whenever rempty=0 and don't-care when rempty=1.
- Reads and writes in the same cycle are both accepted independently, subject to their own flags.
- winc while full and rinc while empty are ignored, with no pointer or memory change.
- Flags are pessimistic, never optimistic: no overflow or underflow is possible.

## Timing
- Reset (rst=1 at a clk edge): wptr, rptr, both Gray registers and all synchronizer flops clear to 0; wfull=0, rempty=1.
- Memory is not reset; rdata is don't-care during and after reset until the first word becomes visible.
- Reset mid-operation discards all contents. Flags take their reset values on the first edge with rst=1.
- Write to empty FIFO at edge N: rempty falls at edge N+SYNC_STAGES+1 (N+3 by default), and rdata then shows that word.
- The write that fills the FIFO (16th occupied slot) raises wfull at the same edge.
- Read from full FIFO at edge N: wfull falls at edge N+SYNC_STAGES+1.
- The read that empties the FIFO raises rempty at the same edge.
- rdata changes combinationally after each accepted read edge, to the next entry.

## Structure
- Package async_fifo_pkg: default parameter constants (DATA_WIDTH, ADDR_WIDTH, SYNC_STAGES) and bin2gray function.
- Sub-module async_fifo_sync: SYNC_STAGES-deep, (ADDR_WIDTH+1)-bit flop chain with synchronous active-high reset to 0. It is instantiated twice, once per pointer direction.
- Top level holds the memory array, pointer/Gray logic and flag registers.

## Test plan
- Reset: assert rst for 2 cycles, then release -> wfull=0 and rempty=1; winc and rinc held low keep both flags unchanged.
- Fill: rinc=0, write 0,1,...,16 on consecutive edges -> wfull rises at the edge of the 16th write (value 15). The 17th write (16) is not stored, and wptr stays unchanged.
- Drain: from full, rinc=1 continuously -> rdata sequence 0..15 in order; rempty rises at the edge of the 16th read, and further rinc has no effect. wfull falls 3 edges after the first read.
- Latency: single write of 0xA5A5A5A5 into empty FIFO -> rempty stays 1 for 2 edges and falls at the 3rd; rdata=0xA5A5A5A5.
- Streaming and wrap: winc=rinc=1 with wdata incrementing on each accepted write, for 100 cycles -> read values are strictly consecutive with no loss or duplication, and pointers wrap past 31.
- Mid-operation reset: 8 words stored, pulse rst for 1 cycle -> rempty=1 and wfull=0 at that edge. The next written word (0x12345678) is the first one read.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg
//   Default geometry of the FIFO and the binary-to-Gray helper shared by
//   the pointer logic.
package async_fifo_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 4;
    localparam int SYNC_STAGES = 2;

    // Pointers carry one extra wrap bit beyond the address.
    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// async_fifo_sync
//   STAGES-deep flop chain carrying a Gray pointer to the opposite side.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset, clears every stage
//     i_d  - pointer in
//     o_q  - pointer out, STAGES edges later
module async_fifo_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// async_fifo
//   Single-clock FIFO built with the Gray-pointer/synchronizer structure of
//   a dual-clock FIFO, so it can be split into two domains later. Flags are
//   pessimistic: they assert immediately on the local side and release only
//   after the other side's pointer has crossed the synchronizer.
//   Ports:
//     clk    - clock, rising edge
//     rst    - synchronous active-high reset
//     winc   - write request, accepted when !wfull
//     wdata  - write data
//     wfull  - full flag
//     rinc   - read request, accepted when !rempty
//     rempty - empty flag
//     rdata  - head-of-FIFO word, first-word fall-through
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH,
    parameter int SS = SYNC_STAGES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          winc,
    input  logic [DW-1:0] wdata,
    output logic          wfull,
    input  logic          rinc,
    output logic          rempty,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [0:DEPTH-1];

    logic [AW:0] r_wbin, r_wgray, r_rbin, r_rgray;
    logic [AW:0] w_wbin_next, w_wgray_next, w_rbin_next, w_rgray_next;
    logic [AW:0] w_rq_wgray, w_wq_rgray, w_full_cmp;
    logic        r_wfull, r_rempty;
    logic        w_wen, w_ren;

    assign w_wen = winc & ~r_wfull;
    assign w_ren = rinc & ~r_rempty;

    assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_wen};
    assign w_rbin_next  = r_rbin + {{AW{1'b0}}, w_ren};
    assign w_wgray_next = bin2gray(w_wbin_next);
    assign w_rgray_next = bin2gray(w_rbin_next);

    // In Gray code "full" means the write pointer is one lap ahead: the two
    // MSBs differ from the read pointer and the rest match.
    assign w_full_cmp = {~w_wq_rgray[AW:AW-1], w_wq_rgray[AW-2:0]};

    async_fifo_sync #(.WIDTH(AW+1), .STAGES(SS)) u_sync_w2r (
        .clk (clk),
        .rst (rst),
        .i_d (r_wgray),
        .o_q (w_rq_wgray)
    );

    async_fifo_sync #(.WIDTH(AW+1), .STAGES(SS)) u_sync_r2w (
        .clk (clk),
        .rst (rst),
        .i_d (r_rgray),
        .o_q (w_wq_rgray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_rbin   <= '0;
            r_rgray  <= '0;
            r_wfull  <= 1'b0;
            r_rempty <= 1'b1;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wgray  <= w_wgray_next;
            r_rbin   <= w_rbin_next;
            r_rgray  <= w_rgray_next;
            r_wfull  <= (w_wgray_next == w_full_cmp);
            r_rempty <= (w_rgray_next == w_rq_wgray);
        end
    end

    // Storage is not reset; nothing is visible until rempty drops.
    always_ff @(posedge clk) begin
        if (w_wen && !rst) r_mem[r_wbin[AW-1:0]] <= wdata;
    end

    assign rdata  = r_mem[r_rbin[AW-1:0]];
    assign wfull  = r_wfull;
    assign rempty = r_rempty;

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;
    import async_fifo_pkg::*;

    localparam int DW    = DATA_WIDTH;
    localparam int S     = SYNC_STAGES;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst, winc, rinc;
    logic [DW-1:0] wdata, rdata;
    logic          wfull, rempty;

    always #5 clk = ~clk;

    async_fifo dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rinc   (rinc),
        .rempty (rempty),
        .rdata  (rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, flags from running totals of
    // accepted writes/reads. The reader sees the writer's total from S+1
    // edges ago, and vice versa.
    logic [DW-1:0] q[$];
    int  wcnt, rcnt;
    int  wdel[S+1];
    int  rdel[S+1];
    bit  m_empty, m_full;

    task automatic model_reset();
        q.delete();
        wcnt = 0;
        rcnt = 0;
        for (int k = 0; k <= S; k++) begin
            wdel[k] = 0;
            rdel[k] = 0;
        end
        m_empty = 1'b1;
        m_full  = 1'b0;
    endtask

    // One clock: model follows the edge, outputs checked at the falling edge.
    task automatic step();
        bit wa, ra;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            wa = winc && !m_full;
            ra = rinc && !m_empty;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(wdata);
            wcnt += int'(wa);
            rcnt += int'(ra);
            m_empty = (rcnt == wdel[S]);
            m_full  = ((wcnt - rdel[S]) == DEPTH);
            for (int k = S; k > 0; k--) begin
                wdel[k] = wdel[k-1];
                rdel[k] = rdel[k-1];
            end
            wdel[0] = wcnt;
            rdel[0] = rcnt;
        end
        @(negedge clk);
        chk("rempty", rempty, m_empty);
        chk("wfull", wfull, m_full);
        if (!m_empty) chk("rdata", rdata, q[0]);
    endtask

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
        model_reset();
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        chk("rst_empty", rempty, 1);
        chk("rst_full", wfull, 0);
        repeat (3) step();
        chk("idle_empty", rempty, 1);
        chk("idle_full", wfull, 0);

        // Fill: 17 writes, the last must be dropped.
        for (int i = 0; i <= DEPTH; i++) begin
            winc = 1'b1; wdata = DW'(i);
            step();
            if (i == DEPTH-2) chk("fill_not_full", wfull, 0);
            if (i == DEPTH-1) chk("fill_full", wfull, 1);
        end
        winc = 1'b0;
        repeat (4) step();

        // Drain: data 0..15 in order, extra reads ignored.
        rinc = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (i < DEPTH) chk("drain_data", rdata, DW'(i));
            step();
            if (i == 2) chk("drain_full_held", wfull, 1);
            if (i == 3) chk("drain_full_fall", wfull, 0);
            if (i == DEPTH-1) chk("drain_empty", rempty, 1);
        end
        rinc = 1'b0;
        step();

        // Latency of a single word into an empty FIFO.
        winc = 1'b1; wdata = 32'hA5A5A5A5;
        step();
        winc = 1'b0;
        chk("lat_e0", rempty, 1);
        step(); chk("lat_e1", rempty, 1);
        step(); chk("lat_e2", rempty, 1);
        step(); chk("lat_e3", rempty, 0);
        chk("lat_data", rdata, 32'hA5A5A5A5);
        rinc = 1'b1; step(); rinc = 1'b0;
        repeat (2) step();

        // Streaming: wdata tracks the accepted-write count, so reads must
        // be consecutive; 100 cycles wraps the 5-bit pointers several times.
        winc = 1'b1; rinc = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wdata = DW'(wcnt);
            step();
        end
        winc = 1'b0;
        repeat (20) step();
        rinc = 1'b0;
        chk("stream_done_empty", rempty, 1);

        // Mid-operation reset.
        winc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wdata = DW'(32'h100 + i);
            step();
        end
        winc = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("mrst_empty", rempty, 1);
        chk("mrst_full", wfull, 0);
        rst = 1'b0;
        winc = 1'b1; wdata = 32'h12345678;
        step();
        winc = 1'b0;
        repeat (4) step();
        chk("mrst_first", rdata, 32'h12345678);
        rinc = 1'b1; step(); rinc = 1'b0; step();

        // Random traffic with varying write/read pressure and rare resets.
        for (int seg = 0; seg < 10; seg++) begin
            int pw, pr;
            pw = int'($urandom_range(10, 95));
            pr = int'($urandom_range(10, 95));
            for (int i = 0; i < 300; i++) begin
                winc  = ($urandom_range(0, 99) < pw);
                rinc  = ($urandom_range(0, 99) < pr);
                wdata = $urandom;
                rst   = ($urandom_range(0, 399) == 0);
                step();
            end
        end
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
